// File: rtl/acq_pkg.sv
// ---------------------------------------------------------------------------
// acq_pkg
// Definitions shared by the acquisition controller and its helpers.
//   - acq_state_t : 3-bit sequencer state encoding
//   - ADDR_WIDTH_DEF / REV_WIDTH_DEF : default widths for the SRAM address
//     (512K x 8 buffer) and for the revolution counter
// ---------------------------------------------------------------------------
package acq_pkg;

   localparam int ADDR_WIDTH_DEF = 19;
   localparam int REV_WIDTH_DEF  = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAITIDX = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_STOP    = 3'd3,
      ST_DONE    = 3'd4
   } acq_state_t;

endpackage

// File: rtl/acq_controller_index_edge_sync.sv
// ---------------------------------------------------------------------------
// index_edge_sync
// Brings an asynchronous drive status line (typically the index pulse) into
// the CLOCK domain and turns each rising edge into a single-cycle pulse.
//
// Ports:
//   CLOCK    in   sampling clock
//   RESET    in   asynchronous reset, active-high
//   SIG_IN   in   raw asynchronous status line
//   IDX_RISE out  registered one-cycle pulse per rising edge of SIG_IN
//
// A rise first sampled on edge N shows up as IDX_RISE high in the cycle
// that follows edge N+2. A line held high produces only one pulse.
// ---------------------------------------------------------------------------
module index_edge_sync (
   input  logic CLOCK,
   input  logic RESET,
   input  logic SIG_IN,
   output logic IDX_RISE
);

   logic sync_meta;
   logic sync_stable;
   logic sync_prev;

   // Two-flop synchroniser, then a delayed copy of the stable level so that
   // the edge detector compares "now" against "one cycle ago". The pulse
   // itself is registered so downstream logic never sees a combinational
   // glitch from the synchroniser chain.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         sync_meta   <= 1'b0;
         sync_stable <= 1'b0;
         sync_prev   <= 1'b0;
         IDX_RISE    <= 1'b0;
      end else begin
         sync_meta   <= SIG_IN;
         sync_stable <= sync_meta;
         sync_prev   <= sync_stable;
         IDX_RISE    <= sync_stable & ~sync_prev;
      end
   end

endmodule

// File: rtl/acq_controller.sv
// ---------------------------------------------------------------------------
// acq_controller
// Sequencing controller for the flux-transition disc reader. A host START
// arms an acquisition, optionally waits for the first index pulse, enables
// the reader (RUN) and turns every reader write strobe into an SRAM write at
// an auto-incrementing address. Acquisition ends on a revolution count, on
// writing the last permitted address, or on host ABORT.
//
// Ports:
//   CLOCK          in   system/acquisition clock
//   RESET          in   asynchronous reset, active-high
//   START          in   pulse: begin acquisition (only from IDLE or DONE)
//   ABORT          in   pulse: stop acquisition
//   WAIT_INDEX_EN  in   hold off capture until the first index rising edge
//   REV_COUNT      in   index edges after capture start that end it; 0 = none
//   ADDR_LIMIT     in   last writable SRAM address
//   FD_INDEX_IN    in   raw asynchronous index pulse from the drive
//   DR_WRITE       in   write strobe from the disc reader
//   RUN            out  registered enable to the disc reader
//   RAM_ADDR       out  SRAM address of the current write
//   RAM_WE         out  SRAM write enable (combinational from DR_WRITE)
//   BUSY           out  high in WAIT_IDX, ACQUIRE and STOP
//   WAITING        out  high in WAIT_IDX
//   DONE           out  high in DONE
//   MEM_FULL       out  sticky: acquisition ended because ADDR_LIMIT was written
//
// Config inputs are captured on the accepted START cycle; on DONE the number
// of captured bytes is RAM_ADDR, or ADDR_LIMIT+1 when MEM_FULL is set.
// ---------------------------------------------------------------------------
module acq_controller
   import acq_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int REV_WIDTH  = REV_WIDTH_DEF
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic                  WAIT_INDEX_EN,
   input  logic [REV_WIDTH-1:0]  REV_COUNT,
   input  logic [ADDR_WIDTH-1:0] ADDR_LIMIT,
   input  logic                  FD_INDEX_IN,
   input  logic                  DR_WRITE,
   output logic                  RUN,
   output logic [ADDR_WIDTH-1:0] RAM_ADDR,
   output logic                  RAM_WE,
   output logic                  BUSY,
   output logic                  WAITING,
   output logic                  DONE,
   output logic                  MEM_FULL
);

   acq_state_t            state_q;
   acq_state_t            state_d;

   logic                  idx_rise;
   logic                  run_q;
   logic                  mem_full_q;
   logic                  abort_flag_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_limit_q;
   logic [REV_WIDTH-1:0]  rev_cnt_q;
   logic [REV_WIDTH-1:0]  rev_cfg_q;

   logic                  start_ok;
   logic                  at_limit;
   logic                  full_hit;
   logic                  rev_hit;
   logic [REV_WIDTH-1:0]  rev_next;

   index_edge_sync u_index_sync (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .SIG_IN   (FD_INDEX_IN),
      .IDX_RISE (idx_rise)
   );

   // Decode of the events the sequencer reacts to. START is only honoured
   // when nothing is in flight; in DONE an ABORT in the same cycle wins.
   // The revolution counter saturates so an unlimited run can never wrap
   // back onto a small REV_COUNT value.
   always_comb begin
      start_ok = START && ((state_q == ST_IDLE) ||
                           ((state_q == ST_DONE) && !ABORT));
      at_limit = (addr_q == addr_limit_q);
      full_hit = RAM_WE && at_limit;
      rev_next = (rev_cnt_q == '1) ? rev_cnt_q : rev_cnt_q + 1'b1;
      rev_hit  = (state_q == ST_ACQUIRE) && idx_rise &&
                 (rev_cfg_q != '0) && (rev_next == rev_cfg_q);
   end

   // State register.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. ABORT, memory full and revolution terminate all lead
   // to the single STOP cycle, which exists so a reader write started on the
   // final ACQUIRE edge still lands in memory.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = WAIT_INDEX_EN ? ST_WAITIDX : ST_ACQUIRE;
            end
         end
         ST_WAITIDX: begin
            if (ABORT) begin
               state_d = ST_STOP;
            end else if (idx_rise) begin
               state_d = ST_ACQUIRE;
            end
         end
         ST_ACQUIRE: begin
            if (ABORT || full_hit || rev_hit) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            state_d = (abort_flag_q || ABORT) ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else if (start_ok) begin
               state_d = WAIT_INDEX_EN ? ST_WAITIDX : ST_ACQUIRE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the current state. In STOP a write is still taken
   // unless the buffer has already been filled.
   always_comb begin
      RAM_WE  = 1'b0;
      BUSY    = 1'b0;
      WAITING = 1'b0;
      DONE    = 1'b0;
      unique case (state_q)
         ST_WAITIDX: begin
            BUSY    = 1'b1;
            WAITING = 1'b1;
         end
         ST_ACQUIRE: begin
            BUSY   = 1'b1;
            RAM_WE = DR_WRITE;
         end
         ST_STOP: begin
            BUSY   = 1'b1;
            RAM_WE = DR_WRITE && !mem_full_q;
         end
         ST_DONE: begin
            DONE = 1'b1;
         end
         default: begin
            RAM_WE = 1'b0;
         end
      endcase
   end

   // Datapath: config capture on START, address/full tracking on each
   // write, revolution counting on index edges while capturing, and the
   // abort flag that decides where STOP exits to. At the limit the address
   // holds instead of wrapping, and MEM_FULL records why we stopped.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         addr_q       <= '0;
         addr_limit_q <= '0;
         rev_cnt_q    <= '0;
         rev_cfg_q    <= '0;
         mem_full_q   <= 1'b0;
         abort_flag_q <= 1'b0;
      end else if (start_ok) begin
         addr_q       <= '0;
         addr_limit_q <= ADDR_LIMIT;
         rev_cnt_q    <= '0;
         rev_cfg_q    <= REV_COUNT;
         mem_full_q   <= 1'b0;
         abort_flag_q <= 1'b0;
      end else begin
         if (RAM_WE) begin
            if (at_limit) begin
               mem_full_q <= 1'b1;
            end else begin
               addr_q <= addr_q + 1'b1;
            end
         end
         if ((state_q == ST_ACQUIRE) && idx_rise) begin
            rev_cnt_q <= rev_next;
         end
         if (ABORT && ((state_q == ST_WAITIDX) || (state_q == ST_ACQUIRE))) begin
            abort_flag_q <= 1'b1;
         end
      end
   end

   // RUN is registered from the next state so it rises on the very edge
   // that enters ACQUIRE and drops on the edge that leaves it.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         run_q <= 1'b0;
      end else begin
         run_q <= (state_d == ST_ACQUIRE);
      end
   end

   assign RUN      = run_q;
   assign RAM_ADDR = addr_q;
   assign MEM_FULL = mem_full_q;

endmodule

// File: tb/tb_acq_controller.sv
// ---------------------------------------------------------------------------
// tb_acq_controller
// Self-checking bench for acq_controller. Stimulus drives one clock cycle at
// a time; a behavioural model of the acquisition rules predicts every SRAM
// write (pushed to a queue) and the host-visible status. A separate monitor
// pops the queue whenever the DUT asserts RAM_WE.
// ---------------------------------------------------------------------------
module tb_acq_controller;

   localparam int AW = 19;
   localparam int RW = 4;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_CAP  = 2;
   localparam int M_STOP = 3;
   localparam int M_DONE = 4;

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b1;
   logic          START = 1'b0;
   logic          ABORT = 1'b0;
   logic          WAIT_INDEX_EN = 1'b0;
   logic [RW-1:0] REV_COUNT = '0;
   logic [AW-1:0] ADDR_LIMIT = '0;
   logic          FD_INDEX_IN = 1'b0;
   logic          DR_WRITE = 1'b0;
   logic          RUN;
   logic [AW-1:0] RAM_ADDR;
   logic          RAM_WE;
   logic          BUSY;
   logic          WAITING;
   logic          DONE;
   logic          MEM_FULL;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];

   // Reference model of the controller's externally visible behaviour.
   int m_mode  = M_IDLE;
   int m_addr  = 0;
   bit m_full  = 1'b0;
   int m_revs  = 0;
   bit m_abort = 1'b0;
   int m_rc    = 0;
   int m_lim   = 0;

   acq_controller #(.ADDR_WIDTH(AW), .REV_WIDTH(RW)) dut (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .START         (START),
      .ABORT         (ABORT),
      .WAIT_INDEX_EN (WAIT_INDEX_EN),
      .REV_COUNT     (REV_COUNT),
      .ADDR_LIMIT    (ADDR_LIMIT),
      .FD_INDEX_IN   (FD_INDEX_IN),
      .DR_WRITE      (DR_WRITE),
      .RUN           (RUN),
      .RAM_ADDR      (RAM_ADDR),
      .RAM_WE        (RAM_WE),
      .BUSY          (BUSY),
      .WAITING       (WAITING),
      .DONE          (DONE),
      .MEM_FULL      (MEM_FULL)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT performs must be the next predicted one.
   always @(negedge CLOCK) begin
      int e;
      if (!RESET && RAM_WE === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected write addr", longint'(RAM_ADDR), -1);
         end else begin
            e = exp_q.pop_front();
            checkOutput("write addr", longint'(RAM_ADDR), e);
         end
      end
   end

   // A predicted write at the current model address.
   task automatic model_write();
      exp_q.push_back(m_addr);
      if (m_addr == m_lim) begin
         m_full = 1'b1;
      end else begin
         m_addr++;
      end
   endtask

   // Model of one clock cycle with the given host/reader inputs.
   task automatic model_step(input bit dw, input bit ab, input bit st);
      case (m_mode)
         M_IDLE, M_DONE: begin
            if (ab && m_mode == M_DONE) begin
               m_mode = M_IDLE;
            end else if (st) begin
               m_addr  = 0;
               m_full  = 1'b0;
               m_revs  = 0;
               m_abort = 1'b0;
               m_rc    = int'(REV_COUNT);
               m_lim   = int'(ADDR_LIMIT);
               m_mode  = WAIT_INDEX_EN ? M_WAIT : M_CAP;
            end
         end
         M_WAIT: begin
            if (ab) begin
               m_abort = 1'b1;
               m_mode  = M_STOP;
            end
         end
         M_CAP: begin
            bit was_full;
            was_full = m_full;
            if (dw) model_write();
            if (ab) m_abort = 1'b1;
            if (ab || (m_full && !was_full)) m_mode = M_STOP;
         end
         M_STOP: begin
            if (dw && !m_full) model_write();
            m_mode = (m_abort || ab) ? M_IDLE : M_DONE;
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   // Model of one index rising edge.
   task automatic model_index();
      if (m_mode == M_WAIT) begin
         m_mode = M_CAP;
      end else if (m_mode == M_CAP) begin
         if (m_revs < (1 << RW) - 1) m_revs++;
         if (m_rc != 0 && m_revs == m_rc) m_mode = M_DONE;
      end
   endtask

   // Drive one cycle (called at posedge+1), update the model, then check the
   // status outputs mid-cycle against the state the model was in.
   task automatic applyStimulus(input bit dw, input bit ab, input bit st, input bit chk);
      int pre_mode;
      int pre_addr;
      pre_mode = m_mode;
      pre_addr = m_addr;
      DR_WRITE = dw;
      ABORT    = ab;
      START    = st;
      model_step(dw, ab, st);
      @(negedge CLOCK);
      if (chk) begin
         checkOutput("RUN", RUN, (pre_mode == M_CAP));
         checkOutput("BUSY", BUSY, (pre_mode >= M_WAIT && pre_mode <= M_STOP));
         checkOutput("WAITING", WAITING, (pre_mode == M_WAIT));
         checkOutput("DONE", DONE, (pre_mode == M_DONE));
         checkOutput("RAM_ADDR", longint'(RAM_ADDR), pre_addr);
      end
      @(posedge CLOCK);
      #1;
      START = 1'b0;
      ABORT = 1'b0;
   endtask

   task automatic start_acq(input bit we, input int rc, input int lim);
      WAIT_INDEX_EN = we;
      REV_COUNT     = RW'(rc);
      ADDR_LIMIT    = AW'(lim);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      // Later config changes must not matter until the next START.
      WAIT_INDEX_EN = 1'($urandom_range(0, 1));
      REV_COUNT     = RW'($urandom_range(0, 15));
      ADDR_LIMIT    = AW'($urandom_range(0, 7));
   endtask

   // Index pulse held high for 'hold' cycles inside a quiet window so its
   // synchroniser latency cannot interact with writes or aborts.
   task automatic index_event(input int hold);
      FD_INDEX_IN = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      model_index();
      for (int i = 1; i < hold; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      FD_INDEX_IN = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Bring any open acquisition to rest and compare final status.
   task automatic settle(input string tag);
      if (m_mode == M_CAP || m_mode == M_WAIT) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput({tag, " writes outstanding"}, exp_q.size(), 0);
      checkOutput({tag, " MEM_FULL"}, MEM_FULL, m_full);
      checkOutput({tag, " DONE"}, DONE, (m_mode == M_DONE));
   endtask

   initial begin
      repeat (3) @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      checkOutput("reset RUN", RUN, 0);
      checkOutput("reset RAM_ADDR", longint'(RAM_ADDR), 0);
      checkOutput("reset MEM_FULL", MEM_FULL, 0);
      checkOutput("reset BUSY", BUSY, 0);
      checkOutput("reset DONE", DONE, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

      // Free-running capture ended by two revolutions.
      start_acq(1'b0, 2, 1000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      end
      index_event(7);
      checkOutput("one rev still busy", BUSY, 1);
      index_event(7);
      settle("revs");
      checkOutput("revs DONE", DONE, 1);
      checkOutput("revs RAM_ADDR", longint'(RAM_ADDR), 5);

      // Wait for index: strobes before arming are ignored; arming edge not counted.
      start_acq(1'b1, 1, 50);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      index_event(7);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      index_event(7);
      settle("armed");
      checkOutput("armed DONE", DONE, 1);
      checkOutput("armed RAM_ADDR", longint'(RAM_ADDR), 2);

      // Memory full with continuous writes.
      start_acq(1'b0, 0, 3);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      settle("full");
      checkOutput("full RAM_ADDR", longint'(RAM_ADDR), 3);
      checkOutput("full MEM_FULL", MEM_FULL, 1);

      // START while busy is ignored; ABORT with a write in the STOP cycle.
      start_acq(1'b0, 0, 100);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("busy START keeps addr", longint'(RAM_ADDR), 4);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      settle("abort");
      checkOutput("abort RAM_ADDR", longint'(RAM_ADDR), 6);
      checkOutput("abort back to idle", BUSY, 0);

      // Asynchronous reset in the middle of a capture.
      start_acq(1'b0, 0, 200);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      DR_WRITE = 1'b1;
      #2 RESET = 1'b1;
      #1;
      checkOutput("async reset RUN", RUN, 0);
      checkOutput("async reset RAM_WE", RAM_WE, 0);
      checkOutput("async reset BUSY", BUSY, 0);
      checkOutput("async reset RAM_ADDR", longint'(RAM_ADDR), 0);
      DR_WRITE = 1'b0;
      m_mode = M_IDLE;
      m_addr = 0;
      m_full = 1'b0;
      exp_q.delete();
      @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      start_acq(1'b0, 0, 200);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      settle("after reset");

      // Index held high counts as a single revolution.
      start_acq(1'b0, 3, 500);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      index_event(50);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("held index still busy", BUSY, 1);
      checkOutput("held index not done", DONE, 0);
      index_event(7);
      checkOutput("two revs still busy", BUSY, 1);
      settle("held");

      // Randomised acquisitions.
      for (int t = 0; t < 25; t++) begin
         int lim;
         lim = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(0, 15));
         start_acq(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), lim);
         if (m_mode == M_WAIT) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
               applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
            index_event(7);
         end
         for (int s = 0; s < 30; s++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 15) begin
               applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
            end else if (r < 19) begin
               index_event(7);
            end else if (m_mode != M_STOP) begin
               applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
            end
         end
         settle("random");
         checkOutput("random RAM_ADDR", longint'(RAM_ADDR), m_addr);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
